// File: rtl/load_store_unit_if.sv
// Pipeline request/response and word-addressed data-memory signals of the load/store unit.
// The pipeline plus memory act as master; the load/store unit is the slave.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // The requester needs no ready signal for the response. resp_valid is a one-cycle pulse,
  // and resp_error/load_data qualify it.
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] address;
  logic [31:0]       store_data;
  logic              resp_valid;
  logic              resp_error;
  logic [31:0]       load_data;
  logic [31:0]       mem_address;
  logic [31:0]       mem_write_data;
  logic              sig_mem_read;
  logic              sig_mem_write;
  logic [31:0]       mem_read_data;

  modport master (
    output req_valid, opcode, address, store_data, mem_read_data,
    input  req_ready, resp_valid, resp_error, load_data,
    input  mem_address, mem_write_data, sig_mem_read, sig_mem_write
  );

  modport slave (
    input  req_valid, opcode, address, store_data, mem_read_data,
    output req_ready, resp_valid, resp_error, load_data,
    output mem_address, mem_write_data, sig_mem_read, sig_mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Big-endian MIPS load/store controller: sub-word loads with extension, sub-word stores as RMW.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of force-aligning them.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus,
  output logic [1:0]       dbg_state
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  state_t            state, state_next;
  logic [5:0]        op_q;
  logic [1:0]        off_q;
  logic [31:0]       word_q;
  logic [31:0]       store_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [ADDR_W-1:0] addr;
  logic [1:0]        size_d;
  logic [1:0]        off_d;
  logic              misalign_d;
  logic              err_d;
  logic [31:0]       word_d;
  logic              accept;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign addr   = bus.address;
  assign word_d = 32'(addr >> 2);
  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    size_d = SZ_ILL;
    case (bus.opcode)
      OP_LB, OP_LBU, OP_SB: size_d = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: size_d = SZ_HALF;
      OP_LW, OP_SW:         size_d = SZ_WORD;
      default:              size_d = SZ_ILL;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_d = ((size_d == SZ_HALF) && addr[0]) ||
                      ((size_d == SZ_WORD) && (addr[1:0] != 2'b00));
  assign off_d      = addr[1:0];
`else
  // Without the trap, the offending low address bits are simply dropped.
  assign misalign_d = 1'b0;
  assign off_d      = (size_d == SZ_HALF) ? {addr[1], 1'b0} :
                      (size_d == SZ_WORD) ? 2'b00 : addr[1:0];
`endif

  assign err_d = (size_d == SZ_ILL) || misalign_d;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (err_d)                      state_next = RESP;
          else if (bus.opcode == OP_SW)   state_next = WRITE;
          else                            state_next = READ;
        end
      end
      // Load opcodes have bit 3 clear; sb/sh continue into the write half of the RMW.
      READ:    state_next = op_q[3] ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      off_q   <= '0;
      word_q  <= '0;
      store_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q    <= bus.opcode;
        off_q   <= off_d;
        word_q  <= word_d;
        store_q <= bus.store_data;
        err_q   <= err_d;
      end
      if (state == READ) rdata_q <= bus.mem_read_data;
    end
  end

  always_comb begin
    byte_sel = rdata_q[7:0];
    case (off_q)
      2'd0:    byte_sel = rdata_q[31:24];
      2'd1:    byte_sel = rdata_q[23:16];
      2'd2:    byte_sel = rdata_q[15:8];
      default: byte_sel = rdata_q[7:0];
    endcase
    half_sel = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
  end

  always_comb begin
    load_ext = '0;
    case (op_q)
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h0, byte_sel};
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0, half_sel};
      OP_LW:   load_ext = rdata_q;
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    merged = store_q;
    if (op_q == OP_SB) begin
      merged = rdata_q;
      case (off_q)
        2'd0:    merged[31:24] = store_q[7:0];
        2'd1:    merged[23:16] = store_q[7:0];
        2'd2:    merged[15:8]  = store_q[7:0];
        default: merged[7:0]   = store_q[7:0];
      endcase
    end else if (op_q == OP_SH) begin
      merged = off_q[1] ? {rdata_q[31:16], store_q[15:0]} : {store_q[15:0], rdata_q[15:0]};
    end
  end

  // Every output is a function of state and registered request fields only.
  assign bus.req_ready      = (state == IDLE);
  assign bus.resp_valid     = (state == RESP);
  assign bus.resp_error     = (state == RESP) && err_q;
  assign bus.load_data      = ((state == RESP) && !err_q) ? load_ext : 32'h0;
  assign bus.mem_address    = word_q;
  assign bus.mem_write_data = (state == WRITE) ? merged : 32'h0;
  assign bus.sig_mem_read   = (state == READ);
  assign bus.sig_mem_write  = (state == WRITE);
  assign dbg_state          = state;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a driver pushes expected responses, and a monitor pops them on resp_valid.
// A small word memory model services the unit's read/write strobes.
module tb_load_store_unit;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic [1:0]  dbg_state;
  int          errors = 0;
  int          checks = 0;
  int          viol = 0;
  int          wr_cnt = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;
  logic [31:0] mem [0:15];
  logic [31:0] w4;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge while the write strobe is high.
  assign bus.mem_read_data = mem[bus.mem_address[3:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899AABB;
    end else if (bus.sig_mem_write) begin
      mem[bus.mem_address[3:0]] <= bus.mem_write_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: strobe rules every cycle, and scoreboard pops on each response.
  always @(negedge clk) begin
    if (bus.sig_mem_read && bus.sig_mem_write) viol++;
    if (!bus.sig_mem_write && bus.mem_write_data != 32'h0) viol++;
    if (bus.sig_mem_write) wr_cnt++;
    if (!reset && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("resp_error", {31'h0, bus.resp_error}, {31'h0, exp_e[32]});
        check("load_data", bus.load_data, exp_e[31:0]);
      end
    end
  end

  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd);
    bus.req_valid  = 1'b1;
    bus.opcode     = op;
    bus.address    = addr;
    bus.store_data = sd;
  endtask

  task automatic issue(input string name, input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic err, input logic [31:0] ld,
                       input int lat, input int nrd, input int nwr, input logic [31:0] wdata);
    int   n, rd, wr, waitc;
    logic seen;
    exp_q.push_back({err, ld});
    @(negedge clk);
    drive(op, addr, sd);
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0; rd = 0; wr = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (bus.sig_mem_read) begin
        rd++;
        check({name, " rd_addr"}, bus.mem_address, addr >> 2);
      end
      if (bus.sig_mem_write) begin
        wr++;
        check({name, " wr_addr"}, bus.mem_address, addr >> 2);
        check({name, " wr_data"}, bus.mem_write_data, wdata);
      end
      if (bus.resp_valid) seen = 1'b1;
    end
    check({name, " latency"}, 32'(n), 32'(lat));
    check({name, " reads"}, 32'(rd), 32'(nrd));
    check({name, " writes"}, 32'(wr), 32'(nwr));
  endtask

  // Pulse reset once the FSM reaches the given cycle after acceptance; no response is expected.
  task automatic reset_at(input string name, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input int cyc, input logic [1:0] st);
    @(negedge clk);
    drive(op, addr, sd);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (cyc) @(negedge clk);
    check({name, " state_before"}, {30'h0, dbg_state}, {30'h0, st});
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check({name, " rd_strobe"}, {31'h0, bus.sig_mem_read}, 32'h0);
    check({name, " wr_strobe"}, {31'h0, bus.sig_mem_write}, 32'h0);
    check({name, " req_ready"}, {31'h0, bus.req_ready}, 32'h1);
    check({name, " resp_valid"}, {31'h0, bus.resp_valid}, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic back_to_back(input logic [31:0] word);
    logic [4:0] rv, rr;
    exp_q.push_back({1'b0, word});
    exp_q.push_back({1'b0, word});
    @(negedge clk);
    drive(OP_LW, 32'h10, 32'h0);
    rv = '0; rr = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rv[k] = bus.resp_valid;
      rr[k] = bus.req_ready;
      if (k == 2) begin
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
      end
    end
    check("b2b resp_pattern", {27'h0, rv}, 32'b10010);
    check("b2b ready_pattern", {27'h0, rr}, 32'b00100);
  endtask

  initial begin
    int wr_before;
    bus.req_valid = 1'b0; bus.opcode = '0; bus.address = '0; bus.store_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst resp_error", {31'h0, bus.resp_error}, 32'h0);
    check("rst load_data", bus.load_data, 32'h0);
    check("rst mem_address", bus.mem_address, 32'h0);
    check("rst mem_write_data", bus.mem_write_data, 32'h0);
    check("rst sig_mem_read", {31'h0, bus.sig_mem_read}, 32'h0);
    check("rst sig_mem_write", {31'h0, bus.sig_mem_write}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0; mem_init = 1'b0;

    issue("lw 10",  OP_LW,  32'h10, 32'h0, 1'b0, 32'h8899AABB, 2, 1, 0, 32'h0);
    issue("lb 11",  OP_LB,  32'h11, 32'h0, 1'b0, 32'hFFFFFF99, 2, 1, 0, 32'h0);
    issue("lbu 11", OP_LBU, 32'h11, 32'h0, 1'b0, 32'h00000099, 2, 1, 0, 32'h0);
    issue("lh 12",  OP_LH,  32'h12, 32'h0, 1'b0, 32'hFFFFAABB, 2, 1, 0, 32'h0);
    issue("lhu 10", OP_LHU, 32'h10, 32'h0, 1'b0, 32'h00008899, 2, 1, 0, 32'h0);
    issue("lb 10",  OP_LB,  32'h10, 32'h0, 1'b0, 32'hFFFFFF88, 2, 1, 0, 32'h0);
    issue("lbu 13", OP_LBU, 32'h13, 32'h0, 1'b0, 32'h000000BB, 2, 1, 0, 32'h0);

    issue("sb 13", OP_SB, 32'h13, 32'h000000CC, 1'b0, 32'h0, 3, 1, 1, 32'h8899AACC);
    check("mem4 after sb13", mem[4], 32'h8899AACC);
    issue("sb 10", OP_SB, 32'h10, 32'hFFFFFF11, 1'b0, 32'h0, 3, 1, 1, 32'h1199AACC);
    issue("sh 12", OP_SH, 32'h12, 32'h00001234, 1'b0, 32'h0, 3, 1, 1, 32'h11991234);
`ifdef LSU_MISALIGN_TRAP_EN
    issue("sh 11", OP_SH, 32'h11, 32'h00005678, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    w4 = 32'h11991234;
`else
    issue("sh 11", OP_SH, 32'h11, 32'h00005678, 1'b0, 32'h0, 3, 1, 1, 32'h56781234);
    w4 = 32'h56781234;
`endif
    check("mem4 after sh", mem[4], w4);
    issue("lw 10 again", OP_LW, 32'h10, 32'h0, 1'b0, w4, 2, 1, 0, 32'h0);

    issue("sw 14",  OP_SW,  32'h14, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1, 32'hDEADBEEF);
    check("mem5 after sw", mem[5], 32'hDEADBEEF);
    issue("lhu 16", OP_LHU, 32'h16, 32'h0, 1'b0, 32'h0000BEEF, 2, 1, 0, 32'h0);
    issue("lh 14",  OP_LH,  32'h14, 32'h0, 1'b0, 32'hFFFFDEAD, 2, 1, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    issue("lw 15", OP_LW, 32'h15, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    issue("lh 17", OP_LH, 32'h17, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);
`else
    issue("lw 15", OP_LW, 32'h15, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0, 32'h0);
    issue("lh 17", OP_LH, 32'h17, 32'h0, 1'b0, 32'hFFFFBEEF, 2, 1, 0, 32'h0);
`endif

    issue("op 2F", 6'h2F, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    issue("op 22", 6'h22, 32'h14, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);

    back_to_back(w4);

    reset_at("rst in write", OP_SB, 32'h10, 32'h000000EE, 2, 2'd2);
    wr_before = wr_cnt;
    reset_at("rst in read", OP_SB, 32'h14, 32'h00000011, 1, 2'd1);
    check("mem5 after rst in read", mem[5], 32'hDEADBEEF);
    check("no write after rst in read", 32'(wr_cnt), 32'(wr_before));
    issue("lw 14 after rst", OP_LW, 32'h14, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0, 32'h0);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    check("strobe_rules", 32'(viol), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
